// File: rtl/time_entry.sv
// ============================================================================
// time_entry: MM:SS digit editor with button edge detection and a
// seconds converter that offers the total over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module time_entry #(
  parameter int VAL_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             next_i,
  input  logic             commit_i,
  input  logic             load_ready_i,
  output logic [3:0]       digit3_o,
  output logic [3:0]       digit2_o,
  output logic [3:0]       digit1_o,
  output logic [3:0]       digit0_o,
  output logic [1:0]       sel_o,
  output logic             load_valid_o,
  output logic [VAL_W-1:0] load_value_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    CONV1 = 2'd1,
    CONV2 = 2'd2,
    OFFER = 2'd3
  } state_t;

  state_t           state_q;
  logic             inc_q, dec_q, next_q, commit_q;
  logic [3:0]       dig_q [4];
  logic [1:0]       sel_q;
  logic [6:0]       m_q;
  logic [5:0]       s_q;
  logic             valid_q;
  logic [VAL_W-1:0] value_q;
  logic             busy_q;

  logic             inc_ev, dec_ev, next_ev, commit_ev;
  logic [3:0]       max_d, cur_d, inc_val_d, dec_val_d;
  logic             all_zero_d;
  logic [6:0]       m_d;
  logic [5:0]       s_d;
  logic [11:0]      sec_d;
  logic [VAL_W-1:0] value_d;

  assign inc_ev    = inc_i    & ~inc_q;
  assign dec_ev    = dec_i    & ~dec_q;
  assign next_ev   = next_i   & ~next_q;
  assign commit_ev = commit_i & ~commit_q;

  // Odd cursor positions hold the tens digits (0-5), even ones the units (0-9).
  assign max_d      = sel_q[0] ? 4'd5 : 4'd9;
  assign cur_d      = dig_q[sel_q];
  assign inc_val_d  = (cur_d >= max_d) ? 4'd0 : cur_d + 4'd1;
  assign dec_val_d  = (cur_d == 4'd0) ? max_d : cur_d - 4'd1;
  assign all_zero_d = ~|{dig_q[3], dig_q[2], dig_q[1], dig_q[0]};

  // x*10 = x*8 + x*2; x*60 = x*64 - x*4.
  assign m_d     = {dig_q[3], 3'b000} + 7'({dig_q[3], 1'b0}) + 7'(dig_q[2]);
  assign s_d     = 6'({dig_q[1], 3'b000}) + 6'({dig_q[1], 1'b0}) + 6'(dig_q[0]);
  assign sec_d   = 12'({m_q, 6'b000000}) - 12'({m_q, 2'b00}) + 12'(s_q);
  assign value_d = VAL_W'(sec_d);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= EDIT;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      next_q   <= 1'b0;
      commit_q <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
      sel_q    <= 2'd3;
      m_q      <= 7'd0;
      s_q      <= 6'd0;
      valid_q  <= 1'b0;
      value_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      inc_q    <= inc_i;
      dec_q    <= dec_i;
      next_q   <= next_i;
      commit_q <= commit_i;
      case (state_q)
        EDIT: begin
          if (commit_ev) begin
            if (!all_zero_d) begin
              state_q <= CONV1;
              busy_q  <= 1'b1;
            end
          end else if (next_ev) begin
            sel_q <= sel_q - 2'd1;
          end else if (inc_ev && !dec_ev) begin
            dig_q[sel_q] <= inc_val_d;
          end else if (dec_ev && !inc_ev) begin
            dig_q[sel_q] <= dec_val_d;
          end
        end
        CONV1: begin
          m_q     <= m_d;
          s_q     <= s_d;
          state_q <= CONV2;
        end
        CONV2: begin
          value_q <= value_d;
          valid_q <= 1'b1;
          state_q <= OFFER;
        end
        OFFER: begin
          if (load_ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
            sel_q   <= 2'd3;
            state_q <= EDIT;
          end
        end
        default: state_q <= EDIT;
      endcase
    end
  end

  assign digit3_o     = dig_q[3];
  assign digit2_o     = dig_q[2];
  assign digit1_o     = dig_q[1];
  assign digit0_o     = dig_q[0];
  assign sel_o        = sel_q;
  assign load_valid_o = valid_q;
  assign load_value_o = value_q;
  assign busy_o       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_time_entry.sv
// ============================================================================
// tb_time_entry: directed vector table plus hand-written multi-cycle sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_time_entry;

  localparam int VAL_W = 12;

  logic             clk_i = 1'b0;
  logic             rst_ni, inc_i, dec_i, next_i, commit_i, load_ready_i;
  logic [3:0]       digit3_o, digit2_o, digit1_o, digit0_o;
  logic [1:0]       sel_o;
  logic             load_valid_o, busy_o;
  logic [VAL_W-1:0] load_value_o;

  int checks   = 0;
  int failures = 0;

  time_entry #(.VAL_W(VAL_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .inc_i        (inc_i),
    .dec_i        (dec_i),
    .next_i       (next_i),
    .commit_i     (commit_i),
    .load_ready_i (load_ready_i),
    .digit3_o     (digit3_o),
    .digit2_o     (digit2_o),
    .digit1_o     (digit1_o),
    .digit0_o     (digit0_o),
    .sel_o        (sel_o),
    .load_valid_o (load_valid_o),
    .load_value_o (load_value_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        inc, dec, nxt, cmt;
    logic [15:0] edig;
    logic [1:0]  esel;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [15:0] digits();
    return {digit3_o, digit2_o, digit1_o, digit0_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic i, input logic d, input logic n, input logic c);
    inc_i = i; dec_i = d; next_i = n; commit_i = c;
    step();
    inc_i = 0; dec_i = 0; next_i = 0; commit_i = 0;
    step();
  endtask

  task automatic set_vec(input int k, input logic i, input logic d, input logic n,
                         input logic c, input logic [15:0] e, input logic [1:0] s);
    vecs[k].inc = i; vecs[k].dec = d; vecs[k].nxt = n; vecs[k].cmt = c;
    vecs[k].edig = e; vecs[k].esel = s;
  endtask

  initial begin
    // inc wraps, dec wraps, inc+dec discarded, next > inc priority, no carry
    set_vec( 0, 1,0,0,0, 16'h1000, 2'd3);
    set_vec( 1, 1,0,0,0, 16'h2000, 2'd3);
    set_vec( 2, 1,0,0,0, 16'h3000, 2'd3);
    set_vec( 3, 1,0,0,0, 16'h4000, 2'd3);
    set_vec( 4, 1,0,0,0, 16'h5000, 2'd3);
    set_vec( 5, 1,0,0,0, 16'h0000, 2'd3);
    set_vec( 6, 1,0,0,0, 16'h1000, 2'd3);
    set_vec( 7, 1,0,0,0, 16'h2000, 2'd3);
    set_vec( 8, 1,0,0,0, 16'h3000, 2'd3);
    set_vec( 9, 0,0,1,0, 16'h3000, 2'd2);
    set_vec(10, 0,1,0,0, 16'h3900, 2'd2);
    set_vec(11, 1,1,0,0, 16'h3900, 2'd2);
    set_vec(12, 0,0,1,0, 16'h3900, 2'd1);
    set_vec(13, 0,1,0,0, 16'h3950, 2'd1);
    set_vec(14, 0,0,1,0, 16'h3950, 2'd0);
    set_vec(15, 0,1,0,0, 16'h3959, 2'd0);
    set_vec(16, 1,0,0,0, 16'h3950, 2'd0);
    set_vec(17, 0,0,1,0, 16'h3950, 2'd3);
    set_vec(18, 1,0,1,0, 16'h3950, 2'd2);
    set_vec(19, 1,0,0,0, 16'h3050, 2'd2);

    rst_ni = 0; inc_i = 0; dec_i = 0; next_i = 0; commit_i = 0; load_ready_i = 0;
    repeat (3) step();
    chk("rst_digits", digits(), 16'h0000);
    chk("rst_sel", sel_o, 3);
    chk("rst_valid", load_valid_o, 0);
    chk("rst_value", load_value_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1;
    step();

    for (int k = 0; k < 20; k++) begin
      inc_i = vecs[k].inc; dec_i = vecs[k].dec; next_i = vecs[k].nxt; commit_i = vecs[k].cmt;
      step();
      chk($sformatf("vec%0d_digits", k), digits(), vecs[k].edig);
      chk($sformatf("vec%0d_sel", k), sel_o, vecs[k].esel);
      chk($sformatf("vec%0d_busy", k), busy_o, 0);
      inc_i = 0; dec_i = 0; next_i = 0; commit_i = 0;
      step();
    end

    // 59:59 conversion with latency and transfer
    rst_ni = 0; step(); rst_ni = 1; step();
    press(0,1,0,0); press(0,0,1,0); press(0,1,0,0); press(0,0,1,0);
    press(0,1,0,0); press(0,0,1,0); press(0,1,0,0);
    chk("max_digits", digits(), 16'h5959);
    chk("max_sel", sel_o, 0);
    load_ready_i = 1; commit_i = 1;
    step(); commit_i = 0;
    chk("max_lat1_valid", load_valid_o, 0);
    chk("max_lat1_busy", busy_o, 1);
    step();
    chk("max_lat2_valid", load_valid_o, 0);
    step();
    chk("max_lat3_valid", load_valid_o, 1);
    chk("max_value", load_value_o, 3599);
    step();
    chk("max_xfer_valid", load_valid_o, 0);
    chk("max_xfer_digits", digits(), 16'h0000);
    chk("max_xfer_sel", sel_o, 3);
    chk("max_xfer_busy", busy_o, 0);
    load_ready_i = 0;

    // 01:30 held in OFFER with backpressure
    press(0,0,1,0); press(1,0,0,0); press(0,0,1,0);
    press(1,0,0,0); press(1,0,0,0); press(1,0,0,0);
    chk("hold_digits", digits(), 16'h0130);
    commit_i = 1; step(); commit_i = 0; step(); step();
    chk("hold_valid0", load_valid_o, 1);
    chk("hold_value0", load_value_o, 90);
    for (int k = 0; k < 20; k++) begin
      inc_i = ((k % 4) == 1);
      step();
      chk($sformatf("hold%0d_valid", k), load_valid_o, 1);
      chk($sformatf("hold%0d_value", k), load_value_o, 90);
      chk($sformatf("hold%0d_digits", k), digits(), 16'h0130);
      chk($sformatf("hold%0d_sel", k), sel_o, 1);
    end
    inc_i = 0;
    next_i = 1; step();
    chk("hold_next_valid", load_valid_o, 1);
    load_ready_i = 1; step(); load_ready_i = 0;
    chk("hold_xfer_valid", load_valid_o, 0);
    chk("hold_xfer_digits", digits(), 16'h0000);
    chk("hold_xfer_sel", sel_o, 3);
    step();
    chk("held_next_no_event_sel", sel_o, 3);
    chk("single_xfer_valid", load_valid_o, 0);
    next_i = 0; step();

    // commit at 00:00 ignored
    commit_i = 1; step(); commit_i = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("zero%0d_busy", k), busy_o, 0);
      chk($sformatf("zero%0d_valid", k), load_valid_o, 0);
      step();
    end

    // reset during OFFER discards the offer
    press(0,0,1,0); press(0,0,1,0); press(0,0,1,0);
    repeat (5) press(1,0,0,0);
    chk("abort_digits", digits(), 16'h0005);
    commit_i = 1; step(); commit_i = 0; step(); step();
    chk("abort_offer_valid", load_valid_o, 1);
    chk("abort_offer_value", load_value_o, 5);
    rst_ni = 0; load_ready_i = 1; step();
    chk("abort_valid", load_valid_o, 0);
    chk("abort_digits0", digits(), 16'h0000);
    chk("abort_sel", sel_o, 3);
    chk("abort_busy", busy_o, 0);
    chk("abort_value", load_value_o, 0);
    rst_ni = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("abort%0d_valid", k), load_valid_o, 0);
      chk($sformatf("abort%0d_busy", k), busy_o, 0);
    end
    load_ready_i = 0;

    // inc held for 50 cycles yields one increment
    inc_i = 1; step();
    chk("held_inc_first", digit3_o, 1);
    repeat (49) step();
    chk("held_inc_digits", digits(), 16'h1000);
    inc_i = 0; step();

    // button held across reset release yields one event
    rst_ni = 0; inc_i = 1; step(); step();
    chk("rst_held_digits", digits(), 16'h0000);
    rst_ni = 1; step();
    chk("rst_release_event", digit3_o, 1);
    step(); step();
    chk("rst_release_once", digit3_o, 1);
    inc_i = 0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
